pwm_fade: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_fade_if.sv | 44 ++++
 rtl/pwm_step_sat.sv | 42 ++++
 rtl/pwm_fade.sv | 171 +++++++++++++++++
 tb/tb_pwm_fade.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the pwm block and its upstream fade controller.
//   PWM_WIDTH  : default width of period / duty / step values
//   PWM_IWIDTH : default width of the fade interval counter
//   fade_state_t : fade controller states (ST_IDLE, ST_RAMP)
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_WIDTH  = 16;
  localparam int PWM_IWIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } fade_state_t;

endpackage

// File: rtl/pwm_fade_if.sv
// -----------------------------------------------------------------------------
// pwm_fade_if
// Configuration handshake between a host and pwm_fade.
//   cfg_valid    : host -> fade, config word valid
//   cfg_ready    : fade -> host, pending slot free
//   cfg_period   : new wave_length (period = cfg_period + 1 clocks)
//   cfg_target   : target high_time
//   cfg_step     : ramp step per step boundary, 0 jumps straight to target
//   cfg_interval : extra periods between ramp steps
// Modports: master (host side), slave (pwm_fade side).
// -----------------------------------------------------------------------------
interface pwm_fade_if
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int IWIDTH = PWM_IWIDTH
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [WIDTH-1:0]  cfg_period;
  logic [WIDTH-1:0]  cfg_target;
  logic [WIDTH-1:0]  cfg_step;
  logic [IWIDTH-1:0] cfg_interval;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_target,
    output cfg_step,
    output cfg_interval,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_target,
    input  cfg_step,
    input  cfg_interval,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_step_sat.sv
// -----------------------------------------------------------------------------
// pwm_step_sat
// Combinational saturating step of a duty value toward its target.
//   cur  : current high_time
//   eff  : effective target
//   step : step size, 0 means jump straight to eff
//   next : cur moved toward eff by step, never overshooting or wrapping
// -----------------------------------------------------------------------------
module pwm_step_sat
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] eff,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Extra carry bit so a large step near the top of the range cannot wrap.
    sum  = {1'b0, cur} + {1'b0, step};
    diff = cur - eff;
    next = eff;
    if (step != '0) begin
      if (cur < eff) begin
        if (sum < {1'b0, eff}) begin
          next = sum[WIDTH-1:0];
        end
      end else if (cur > eff) begin
        // Only step down by the full amount when it stays above eff.
        if (diff > step) begin
          next = cur - step;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_fade.sv
// -----------------------------------------------------------------------------
// pwm_fade
// Upstream control stage for the pwm block. Accepts period / target / ramp
// settings over a valid/ready handshake, holds one pending config, and applies
// it at the next pwm period boundary. high_time then ramps toward the
// effective target by cfg_step every (cfg_interval + 1) periods.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cfg          : pwm_fade_if.slave configuration handshake
//   last_cycle   : from pwm, one-clk pulse at each period boundary
//   wave_length  : registered period value to pwm
//   high_time    : registered duty value to pwm
//   busy         : high while high_time differs from the effective target
//   done         : one-clk pulse after high_time reaches the effective target
// -----------------------------------------------------------------------------
module pwm_fade
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int IWIDTH = PWM_IWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  pwm_fade_if.slave        cfg,
  input  logic             last_cycle,
  output logic [WIDTH-1:0] wave_length,
  output logic [WIDTH-1:0] high_time,
  output logic             busy,
  output logic             done
);

  fade_state_t       state_q, state_d;
  logic [WIDTH-1:0]  wave_q, wave_d;
  logic [WIDTH-1:0]  high_q, high_d;
  logic [WIDTH-1:0]  eff_q, eff_d;
  logic [WIDTH-1:0]  step_q, step_d;
  logic [IWIDTH-1:0] intvl_q, intvl_d;
  logic [IWIDTH-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]  pend_period_q, pend_period_d;
  logic [WIDTH-1:0]  pend_target_q, pend_target_d;
  logic [WIDTH-1:0]  pend_step_q, pend_step_d;
  logic [IWIDTH-1:0] pend_intvl_q, pend_intvl_d;

  logic [WIDTH:0]    period_p1;
  logic [WIDTH:0]    target_ext;
  logic [WIDTH:0]    eff_wide;
  logic [WIDTH-1:0]  eff_new;
  logic              clamp_hi;
  logic [WIDTH-1:0]  step_next;
  logic              accept;

  // Effective target of the pending config: min(target, period+1), with the
  // 100%-duty value period+1 needing one extra bit before saturation.
  assign period_p1  = {1'b0, pend_period_q} + (WIDTH+1)'(1);
  assign target_ext = {1'b0, pend_target_q};
  assign eff_wide   = (target_ext < period_p1) ? target_ext : period_p1;
  assign eff_new    = eff_wide[WIDTH] ? '1 : eff_wide[WIDTH-1:0];
  assign clamp_hi   = ({1'b0, high_q} > period_p1);

  assign accept     = cfg.cfg_valid && ready_q;

  pwm_step_sat #(
    .WIDTH (WIDTH)
  ) u_step_sat (
    .cur  (high_q),
    .eff  (eff_q),
    .step (step_q),
    .next (step_next)
  );

  always_comb begin
    state_d       = state_q;
    wave_d        = wave_q;
    high_d        = high_q;
    eff_d         = eff_q;
    step_d        = step_q;
    intvl_d       = intvl_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_target_d = pend_target_q;
    pend_step_d   = pend_step_q;
    pend_intvl_d  = pend_intvl_q;

    if (last_cycle && pend_valid_q) begin
      // Application has priority over a ramp step on the same boundary.
      wave_d       = pend_period_q;
      high_d       = clamp_hi ? eff_new : high_q;
      eff_d        = eff_new;
      step_d       = pend_step_q;
      intvl_d      = pend_intvl_q;
      cnt_d        = pend_intvl_q;
      pend_valid_d = 1'b0;
      if (high_d == eff_new) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RAMP;
      end
    end else if (last_cycle && (state_q == ST_RAMP)) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - IWIDTH'(1);
      end else begin
        high_d = step_next;
        cnt_d  = intvl_q;
        if (step_next == eff_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    // Acceptance cannot coincide with application: ready is low while a
    // config is pending, so the slot is never overwritten.
    if (accept) begin
      pend_valid_d  = 1'b1;
      pend_period_d = cfg.cfg_period;
      pend_target_d = cfg.cfg_target;
      pend_step_d   = cfg.cfg_step;
      pend_intvl_d  = cfg.cfg_interval;
    end

    ready_d = !pend_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wave_q        <= '0;
      high_q        <= '0;
      eff_q         <= '0;
      step_q        <= '0;
      intvl_q       <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_target_q <= '0;
      pend_step_q   <= '0;
      pend_intvl_q  <= '0;
    end else begin
      state_q       <= state_d;
      wave_q        <= wave_d;
      high_q        <= high_d;
      eff_q         <= eff_d;
      step_q        <= step_d;
      intvl_q       <= intvl_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_target_q <= pend_target_d;
      pend_step_q   <= pend_step_d;
      pend_intvl_q  <= pend_intvl_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign wave_length   = wave_q;
  assign high_time     = high_q;
  assign busy          = (state_q == ST_RAMP);
  assign done          = done_q;

endmodule

// File: tb/tb_pwm_fade.sv
// -----------------------------------------------------------------------------
// tb_pwm_fade
// Drives a 16-bit and an 8-bit pwm_fade from shared clk/rst/last_cycle and
// compares every output after every edge with a per-boundary reference model.
// -----------------------------------------------------------------------------
module tb_pwm_fade;

  typedef struct {
    int wave;
    int high;
    int eff;
    int step;
    int intv;
    int cnt;
    bit ramp;
    bit done;
    bit ready;
    bit pend;
    int p_period;
    int p_target;
    int p_step;
    int p_intv;
  } model_t;

  logic clk = 1'b0;
  logic rst;
  logic last_cycle;

  always #5 clk = ~clk;

  pwm_fade_if #(.WIDTH(16), .IWIDTH(8)) if_a ();
  pwm_fade_if #(.WIDTH(8),  .IWIDTH(8)) if_b ();

  logic [15:0] wl_a, ht_a;
  logic        busy_a, done_a;
  logic [7:0]  wl_b, ht_b;
  logic        busy_b, done_b;

  pwm_fade #(.WIDTH(16), .IWIDTH(8)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .cfg         (if_a),
    .last_cycle  (last_cycle),
    .wave_length (wl_a),
    .high_time   (ht_a),
    .busy        (busy_a),
    .done        (done_a)
  );

  pwm_fade #(.WIDTH(8), .IWIDTH(8)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .cfg         (if_b),
    .last_cycle  (last_cycle),
    .wave_length (wl_b),
    .high_time   (ht_b),
    .busy        (busy_b),
    .done        (done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  model_t ma, mb;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: the pending config lands on a boundary,
  // otherwise a ramping value steps toward eff every (interval+1) boundaries.
  function automatic model_t model_edge(input model_t m, input bit r, input bit v,
                                        input bit last, input int per, input int tgt,
                                        input int stp, input int itv, input int maxv);
    model_t n;
    int p1;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.done = 1'b0;
    if (last && m.pend) begin
      p1     = m.p_period + 1;
      n.wave = m.p_period;
      n.eff  = (m.p_target < p1) ? m.p_target : p1;
      if (n.eff > maxv) n.eff = maxv;
      if (m.high > p1) n.high = n.eff;
      n.step = m.p_step;
      n.intv = m.p_intv;
      n.cnt  = m.p_intv;
      n.pend = 1'b0;
      n.ramp = (n.high != n.eff);
      n.done = !n.ramp;
    end else if (last && m.ramp) begin
      if (m.cnt > 0) begin
        n.cnt = m.cnt - 1;
      end else begin
        if (m.step == 0)             n.high = m.eff;
        else if (m.high < m.eff)     n.high = (m.high + m.step >= m.eff) ? m.eff : m.high + m.step;
        else                         n.high = (m.high - m.step <= m.eff) ? m.eff : m.high - m.step;
        n.cnt = m.intv;
        if (n.high == m.eff) begin
          n.ramp = 1'b0;
          n.done = 1'b1;
        end
      end
    end
    if (v && m.ready) begin
      n.pend     = 1'b1;
      n.p_period = per;
      n.p_target = tgt;
      n.p_step   = stp;
      n.p_intv   = itv;
    end
    n.ready = !n.pend;
    return n;
  endfunction

  task automatic step_clk();
    bit r, l, va, vb;
    int pa, ta, sa, ia, pb, tb, sb, ib;
    r  = rst;        l  = last_cycle;
    va = if_a.cfg_valid;
    pa = int'(if_a.cfg_period); ta = int'(if_a.cfg_target);
    sa = int'(if_a.cfg_step);   ia = int'(if_a.cfg_interval);
    vb = if_b.cfg_valid;
    pb = int'(if_b.cfg_period); tb = int'(if_b.cfg_target);
    sb = int'(if_b.cfg_step);   ib = int'(if_b.cfg_interval);
    @(posedge clk);
    #1;
    ma = model_edge(ma, r, va, l, pa, ta, sa, ia, 65535);
    mb = model_edge(mb, r, vb, l, pb, tb, sb, ib, 255);
    check_eq("wl_a",    int'(wl_a),           ma.wave);
    check_eq("ht_a",    int'(ht_a),           ma.high);
    check_eq("busy_a",  int'(busy_a),         int'(ma.ramp));
    check_eq("done_a",  int'(done_a),         int'(ma.done));
    check_eq("ready_a", int'(if_a.cfg_ready), int'(ma.ready));
    check_eq("wl_b",    int'(wl_b),           mb.wave);
    check_eq("ht_b",    int'(ht_b),           mb.high);
    check_eq("busy_b",  int'(busy_b),         int'(mb.ramp));
    check_eq("done_b",  int'(done_b),         int'(mb.done));
    check_eq("ready_b", int'(if_b.cfg_ready), int'(mb.ready));
  endtask

  task automatic boundary();
    last_cycle = 1'b1;
    step_clk();
    last_cycle = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  // Hold valid until the model reports the slot free at the edge; bounded.
  task automatic send(input bit sel_b, input int per, input int tgt, input int stp, input int itv);
    bit acc;
    acc = 1'b0;
    if (!sel_b) begin
      if_a.cfg_period = 16'(per); if_a.cfg_target = 16'(tgt);
      if_a.cfg_step = 16'(stp);   if_a.cfg_interval = 8'(itv);
      if_a.cfg_valid = 1'b1;
    end else begin
      if_b.cfg_period = 8'(per);  if_b.cfg_target = 8'(tgt);
      if_b.cfg_step = 8'(stp);    if_b.cfg_interval = 8'(itv);
      if_b.cfg_valid = 1'b1;
    end
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = sel_b ? mb.ready : ma.ready;
      step_clk();
    end
    if_a.cfg_valid = 1'b0;
    if_b.cfg_valid = 1'b0;
    check_eq("send_accepted", int'(acc), 1);
  endtask

  initial begin
    int exp3[3];
    int exp4[9];
    int exp6[3];
    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1'b1;
    last_cycle = 1'b0;
    if_a.cfg_valid = 1'b0; if_a.cfg_period = '0; if_a.cfg_target = '0;
    if_a.cfg_step = '0;    if_a.cfg_interval = '0;
    if_b.cfg_valid = 1'b0; if_b.cfg_period = '0; if_b.cfg_target = '0;
    if_b.cfg_step = '0;    if_b.cfg_interval = '0;

    // Reset values and jump-to-target with step=0.
    do_reset();
    check_eq("post_rst_ready", int'(if_a.cfg_ready), 1);
    send(1'b0, 9, 4, 0, 0);
    boundary();
    check_eq("t1_wl", int'(wl_a), 9);
    boundary();
    check_eq("t1_ht", int'(ht_a), 4);
    check_eq("t1_done", int'(done_a), 1);
    step_clk();
    check_eq("t1_done_end", int'(done_a), 0);
    check_eq("t1_busy", int'(busy_a), 0);

    // Ramp up 0 -> 50 by 20 each period.
    do_reset();
    send(1'b0, 99, 50, 20, 0);
    boundary();
    check_eq("t2_start", int'(ht_a), 0);
    exp3 = '{20, 40, 50};
    for (int k = 0; k < 3; k++) begin
      step_clk();
      boundary();
      check_eq("t2_ramp", int'(ht_a), exp3[k]);
    end
    check_eq("t2_done", int'(done_a), 1);

    // Ramp down 50 -> 5 by 20, holding three periods per step.
    send(1'b0, 99, 5, 20, 2);
    boundary();
    exp4 = '{50, 50, 30, 30, 30, 10, 10, 10, 5};
    for (int k = 0; k < 9; k++) begin
      step_clk();
      boundary();
      check_eq("t3_ramp", int'(ht_a), exp4[k]);
    end

    // Acceptance coinciding with last_cycle waits for the next boundary;
    // a second valid stalls until the slot is free again.
    if_a.cfg_period = 16'd99; if_a.cfg_target = 16'd80;
    if_a.cfg_step = 16'd0;    if_a.cfg_interval = 8'd0;
    if_a.cfg_valid = 1'b1;
    last_cycle = 1'b1;
    step_clk();
    last_cycle = 1'b0;
    check_eq("t4_ready_low", int'(if_a.cfg_ready), 0);
    check_eq("t4_not_applied", int'(busy_a), 0);
    if_a.cfg_target = 16'd20;
    step_clk();
    step_clk();
    check_eq("t4_stall", int'(if_a.cfg_ready), 0);
    boundary();
    check_eq("t4_applied", int'(busy_a), 1);
    step_clk();
    if_a.cfg_valid = 1'b0;
    boundary();
    boundary();
    check_eq("t4_retarget", int'(ht_a), 20);

    // Saturation at 100% duty (16-bit) and full-range ramp (8-bit).
    send(1'b0, 9, 2, 0, 0);
    boundary();
    boundary();
    send(1'b0, 9, 200, 3, 0);
    boundary();
    repeat (3) boundary();
    check_eq("t5_sat_a", int'(ht_a), 10);
    send(1'b1, 255, 255, 100, 0);
    boundary();
    exp6 = '{100, 200, 255};
    for (int k = 0; k < 3; k++) begin
      boundary();
      check_eq("t5_ramp_b", int'(ht_b), exp6[k]);
    end

    // Reset mid-ramp with a config pending.
    send(1'b0, 99, 60, 10, 0);
    boundary();
    boundary();
    boundary();
    check_eq("t6_mid", int'(ht_a), 30);
    send(1'b0, 99, 90, 5, 0);
    rst = 1'b1;
    step_clk();
    check_eq("t6_rst_ht", int'(ht_a), 0);
    check_eq("t6_rst_ready", int'(if_a.cfg_ready), 0);
    step_clk();
    rst = 1'b0;
    repeat (3) boundary();
    check_eq("t6_no_resume", int'(ht_a), 0);

    // Randomized traffic on both instances.
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      last_cycle = ($urandom_range(0, 3) == 0);
      if_a.cfg_valid    = ($urandom_range(0, 2) == 0);
      if_a.cfg_period   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 300));
      if_a.cfg_target   = 16'($urandom_range(0, 400));
      if_a.cfg_step     = 16'($urandom_range(0, 50));
      if_a.cfg_interval = 8'($urandom_range(0, 3));
      if_b.cfg_valid    = ($urandom_range(0, 2) == 0);
      if_b.cfg_period   = 8'($urandom);
      if_b.cfg_target   = 8'($urandom);
      if_b.cfg_step     = 8'($urandom_range(0, 80));
      if_b.cfg_interval = 8'($urandom_range(0, 2));
      step_clk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
